lsu_bus: RTL and testbench

Parametrised multi-cycle load/store unit and the successor to the single-cycle DPI-backed LSU. It sits between EXU and WBU on the valid/ready pipeline. Memory accesses go out on a request/response bus with byte strobes, so SRAM, AXI-lite bridges and wait states plug in directly. Over the previous generation it adds XLEN generalisation (32/64), address-offset lane steering, misalignment detection, bus-error reporting and back-pressure on every interface.

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_bus_if.sv | 66 ++++++
 rtl/lsu_lane.sv | 62 ++++++
 rtl/lsu_bus.sv | 121 ++++++++++++
 tb/tb_lsu_bus.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the multi-cycle load/store unit:
//                opt-field bit positions, access-size encodings, FSM state
//                encodings, the latched-op record, the byte-mask helper and
//                the misalignment rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   // Bit positions inside the 4-bit opt field {store, unsigned, size[1:0]}
   localparam int OPT_STORE = 3;
   localparam int OPT_UNS   = 2;

   // Access-size encodings
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RSP  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Decoded op held for the whole transaction
   typedef struct packed {
      logic       store;
      logic       uns;
      logic [1:0] size;
   } op_t;

   // Unshifted byte mask of an access: 1/3/F/FF for B/H/W/D
   function automatic logic [7:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_B:    size_mask = 8'h01;
         SZ_H:    size_mask = 8'h03;
         SZ_W:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

   // Natural-alignment check; a doubleword on a 32-bit datapath is never legal
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [2:0] lo,
                                          input logic       is64);
      case (size)
         SZ_H:    is_misaligned = lo[0];
         SZ_W:    is_misaligned = (lo[1:0] != 2'b00);
         SZ_D:    is_misaligned = !is64 || (lo != 3'b000);
         default: is_misaligned = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_bus_if
//  Description : Bundle of the LSU's three handshake interfaces: the EXU-side
//                op input, the WBU-side result output and the memory
//                request/response bus. Signal names keep the LSU's i_/o_
//                direction so both sides read the same.
//  Modports    : master - the LSU itself (drives o_*, samples i_*)
//                slave  - the surrounding pipeline / memory (drives i_*)
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_bus_if #(
   parameter int XLEN = 32
);
   localparam int STRB_W = XLEN / 8;

   // EXU -> LSU
   logic              i_pre_valid;
   logic              o_pre_ready;
   logic              i_mem_en;
   logic [3:0]        i_opt;
   logic [XLEN-1:0]   i_addr;
   logic [XLEN-1:0]   i_regst;
   // LSU -> WBU
   logic              o_post_valid;
   logic              i_post_ready;
   logic [XLEN-1:0]   o_regld;
   logic              o_fault;
   logic [XLEN-1:0]   o_fault_addr;
   // Memory request
   logic              o_req_valid;
   logic              i_req_ready;
   logic [XLEN-1:0]   o_req_addr;
   logic              o_req_wen;
   logic [XLEN-1:0]   o_req_wdata;
   logic [STRB_W-1:0] o_req_wstrb;
   // Memory response
   logic              i_rsp_valid;
   logic              o_rsp_ready;
   logic [XLEN-1:0]   i_rsp_data;
   logic              i_rsp_err;

   modport master (
      input  i_pre_valid, i_mem_en, i_opt, i_addr, i_regst,
      output o_pre_ready,
      output o_post_valid, o_regld, o_fault, o_fault_addr,
      input  i_post_ready,
      output o_req_valid, o_req_addr, o_req_wen, o_req_wdata, o_req_wstrb,
      input  i_req_ready,
      input  i_rsp_valid, i_rsp_data, i_rsp_err,
      output o_rsp_ready
   );

   modport slave (
      output i_pre_valid, i_mem_en, i_opt, i_addr, i_regst,
      input  o_pre_ready,
      input  o_post_valid, o_regld, o_fault, o_fault_addr,
      output i_post_ready,
      input  o_req_valid, o_req_addr, o_req_wen, o_req_wdata, o_req_wstrb,
      output i_req_ready,
      output i_rsp_valid, i_rsp_data, i_rsp_err,
      input  o_rsp_ready
   );

endinterface
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane
//  Description : Combinational byte-lane steering. Places store data and
//                strobes on the lanes selected by the address offset, and
//                pulls load data down from those lanes with sign/zero
//                extension.
//  Ports       : size_i, uns_i, store_i - latched access type
//                off_i                  - address offset within the bus word
//                regst_i                - store source data
//                rsp_data_i             - full aligned read word
//                wstrb_o, wdata_o       - lane-placed strobes and data
//                ld_data_o              - extracted, extended load value
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  wire logic [1:0]                  size_i,
   input  wire logic                        uns_i,
   input  wire logic                        store_i,
   input  wire logic [$clog2(XLEN/8)-1:0]   off_i,
   input  wire logic [XLEN-1:0]             regst_i,
   input  wire logic [XLEN-1:0]             rsp_data_i,
   output logic      [XLEN/8-1:0]           wstrb_o,
   output logic      [XLEN-1:0]             wdata_o,
   output logic      [XLEN-1:0]             ld_data_o
);
   localparam int STRB_W = XLEN / 8;

   logic [XLEN-1:0] sh;     // read word with the addressed byte moved to lane 0
   logic [XLEN-1:0] w_ext;  // word-size load result
   logic            sx;     // sign-extension enable

   assign sx = ~uns_i;
   assign sh = rsp_data_i >> {off_i, 3'b000};

   // A word load only needs extending when the datapath is wider than a word
   generate
      if (XLEN == 64) begin : g_w64
         assign w_ext = {{32{sx & sh[31]}}, sh[31:0]};
      end else begin : g_w32
         assign w_ext = sh;
      end
   endgenerate

   always_comb begin
      // Reads drive no strobes so a write-capable slave can key off wstrb alone
      wstrb_o = store_i ? (STRB_W'(size_mask(size_i)) << off_i) : '0;
      wdata_o = regst_i << {off_i, 3'b000};
      case (size_i)
         SZ_B:    ld_data_o = {{(XLEN-8){sx & sh[7]}}, sh[7:0]};
         SZ_H:    ld_data_o = {{(XLEN-16){sx & sh[15]}}, sh[15:0]};
         SZ_W:    ld_data_o = w_ext;
         default: ld_data_o = sh;   // doubleword: full width, no extension
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_bus.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_bus
//  Description : Multi-cycle load/store unit between EXU and WBU. Accepts one
//                op at a time, issues at most one request on a strobed
//                request/response bus, and returns the extended load value
//                or a fault (misalignment or bus error) to WBU.
//  Ports       : i_clk, i_rst - clock, synchronous active-high reset
//                bus          - lsu_bus_if.master: EXU op handshake, WBU
//                               result handshake, memory request/response
//  Notes       : XLEN must equal the XLEN of the connected interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_bus
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  wire logic  i_clk,
   input  wire logic  i_rst,
   lsu_bus_if.master  bus
);
   localparam int STRB_W = XLEN / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   logic [1:0]        state_q, state_d;
   op_t               op_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   regst_q;
   logic [XLEN-1:0]   regld_q;
   logic              fault_q;
   logic [XLEN-1:0]   fault_addr_q;

   logic              w_accept;
   logic              w_mis;
   logic              w_early_done;  // op completes without touching the bus
   logic [STRB_W-1:0] w_wstrb;
   logic [XLEN-1:0]   w_wdata;
   logic [XLEN-1:0]   w_ld_data;

   assign w_accept     = (state_q == ST_IDLE) && bus.i_pre_valid;
   assign w_mis        = is_misaligned(bus.i_opt[1:0], bus.i_addr[2:0], XLEN == 64);
   // Pass-through ops are never checked for alignment
   assign w_early_done = !bus.i_mem_en || w_mis;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.i_pre_valid)  state_d = w_early_done ? ST_DONE : ST_REQ;
         ST_REQ:  if (bus.i_req_ready)  state_d = ST_RSP;
         ST_RSP:  if (bus.i_rsp_valid)  state_d = ST_DONE;
         ST_DONE: if (bus.i_post_ready) state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         op_q         <= '0;
         addr_q       <= '0;
         regst_q      <= '0;
         regld_q      <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         state_q <= state_d;
         if (w_accept) begin
            op_q.store   <= bus.i_opt[OPT_STORE];
            op_q.uns     <= bus.i_opt[OPT_UNS];
            op_q.size    <= bus.i_opt[1:0];
            addr_q       <= bus.i_addr;
            regst_q      <= bus.i_regst;
            regld_q      <= '0;
            fault_q      <= bus.i_mem_en && w_mis;
            fault_addr_q <= (bus.i_mem_en && w_mis) ? bus.i_addr : '0;
         end
         if ((state_q == ST_RSP) && bus.i_rsp_valid) begin
            if (bus.i_rsp_err) begin
               fault_q      <= 1'b1;
               fault_addr_q <= addr_q;
               regld_q      <= '0;
            end else begin
               regld_q      <= op_q.store ? '0 : w_ld_data;
            end
         end
      end
   end

   lsu_lane #(
      .XLEN (XLEN)
   ) u_lane (
      .size_i     (op_q.size),
      .uns_i      (op_q.uns),
      .store_i    (op_q.store),
      .off_i      (addr_q[OFF_W-1:0]),
      .regst_i    (regst_q),
      .rsp_data_i (bus.i_rsp_data),
      .wstrb_o    (w_wstrb),
      .wdata_o    (w_wdata),
      .ld_data_o  (w_ld_data)
   );

   // Handshake outputs are pure state decodes; request fields come from
   // latched registers, so they hold steady for as long as REQ is stalled.
   assign bus.o_pre_ready  = (state_q == ST_IDLE);
   assign bus.o_req_valid  = (state_q == ST_REQ);
   assign bus.o_rsp_ready  = (state_q == ST_RSP);
   assign bus.o_post_valid = (state_q == ST_DONE);

   assign bus.o_req_addr   = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
   assign bus.o_req_wen    = op_q.store;
   assign bus.o_req_wdata  = w_wdata;
   assign bus.o_req_wstrb  = w_wstrb;

   assign bus.o_regld      = regld_q;
   assign bus.o_fault      = fault_q;
   assign bus.o_fault_addr = fault_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_bus
//  Description : Scoreboard bench for lsu_bus. A 32-bit and a 64-bit instance
//                share the stimulus signals; sel steers pre_valid and picks
//                which instance the monitor watches. Expected bus requests
//                and WBU results are queued by the stimulus and checked by an
//                independent negedge monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_bus;

   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
   } req_e;

   typedef struct {
      logic [63:0] regld;
      logic        fault;
      logic [63:0] fa;
      int          lat;     // accept-to-handshake edges, -1 = not checked
   } post_e;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        pre_valid = 1'b0;
   logic        mem_en = 1'b0;
   logic [3:0]  opt = 4'h0;
   logic [63:0] addr = '0;
   logic [63:0] regst = '0;
   logic        post_ready = 1'b0;
   logic        req_ready = 1'b0;
   logic        rsp_valid = 1'b0;
   logic [63:0] rsp_data = '0;
   logic        rsp_err = 1'b0;

   int n_vec = 0, n_fail = 0;
   int cyc = 0, acc_cyc = 0;
   int n_req_hs = 0, n_rsp_hs = 0, n_post_hs = 0;
   int n_req_exp = 0, n_rsp_exp = 0, n_post_exp = 0;

   req_e  req_q[$];
   post_e post_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lsu_bus_if #(.XLEN(32)) if32 ();
   lsu_bus_if #(.XLEN(64)) if64 ();

   assign if32.i_pre_valid  = pre_valid & ~sel;
   assign if32.i_mem_en     = mem_en;
   assign if32.i_opt        = opt;
   assign if32.i_addr       = addr[31:0];
   assign if32.i_regst      = regst[31:0];
   assign if32.i_post_ready = post_ready;
   assign if32.i_req_ready  = req_ready;
   assign if32.i_rsp_valid  = rsp_valid;
   assign if32.i_rsp_data   = rsp_data[31:0];
   assign if32.i_rsp_err    = rsp_err;

   assign if64.i_pre_valid  = pre_valid & sel;
   assign if64.i_mem_en     = mem_en;
   assign if64.i_opt        = opt;
   assign if64.i_addr       = addr;
   assign if64.i_regst      = regst;
   assign if64.i_post_ready = post_ready;
   assign if64.i_req_ready  = req_ready;
   assign if64.i_rsp_valid  = rsp_valid;
   assign if64.i_rsp_data   = rsp_data;
   assign if64.i_rsp_err    = rsp_err;

   lsu_bus #(.XLEN(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(if32.master));
   lsu_bus #(.XLEN(64)) dut64 (.i_clk(clk), .i_rst(rst), .bus(if64.master));

   // Outputs of the instance currently selected
   logic        m_pre_ready, m_post_valid, m_fault, m_req_valid, m_req_wen, m_rsp_ready;
   logic [63:0] m_regld, m_fault_addr, m_req_addr, m_req_wdata;
   logic [7:0]  m_req_wstrb;

   assign m_pre_ready  = sel ? if64.o_pre_ready  : if32.o_pre_ready;
   assign m_post_valid = sel ? if64.o_post_valid : if32.o_post_valid;
   assign m_fault      = sel ? if64.o_fault      : if32.o_fault;
   assign m_req_valid  = sel ? if64.o_req_valid  : if32.o_req_valid;
   assign m_req_wen    = sel ? if64.o_req_wen    : if32.o_req_wen;
   assign m_rsp_ready  = sel ? if64.o_rsp_ready  : if32.o_rsp_ready;
   assign m_regld      = sel ? if64.o_regld      : 64'(if32.o_regld);
   assign m_fault_addr = sel ? if64.o_fault_addr : 64'(if32.o_fault_addr);
   assign m_req_addr   = sel ? if64.o_req_addr   : 64'(if32.o_req_addr);
   assign m_req_wdata  = sel ? if64.o_req_wdata  : 64'(if32.o_req_wdata);
   assign m_req_wstrb  = sel ? if64.o_req_wstrb  : 8'(if32.o_req_wstrb);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      req_e  re;
      post_e pe;
      if (!rst) begin
         if (pre_valid && m_pre_ready) acc_cyc = cyc;
         if (rsp_valid && m_rsp_ready) n_rsp_hs++;
         if (m_req_valid) begin
            if (req_q.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL req_spurious: got request addr %h, required none", m_req_addr);
            end else begin
               re = req_q[0];
               chk("req_addr",  m_req_addr, re.addr);
               chk("req_wen",   64'(m_req_wen), 64'(re.wen));
               chk("req_wstrb", 64'(m_req_wstrb), 64'(re.wstrb));
               if (re.wen) chk("req_wdata", m_req_wdata, re.wdata);
               if (req_ready) begin
                  void'(req_q.pop_front());
                  n_req_hs++;
               end
            end
         end
         if (m_post_valid) begin
            if (post_q.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL post_spurious: got result %h, required none", m_regld);
            end else begin
               pe = post_q[0];
               chk("regld",      m_regld, pe.regld);
               chk("fault",      64'(m_fault), 64'(pe.fault));
               chk("fault_addr", m_fault_addr, pe.fa);
               if (post_ready) begin
                  if (pe.lat >= 0) chk("latency", 64'(cyc - acc_cyc), 64'(pe.lat));
                  void'(post_q.pop_front());
                  n_post_hs++;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int k);
      case (k)
         0:       sig = m_pre_ready;
         1:       sig = m_req_valid;
         2:       sig = m_rsp_ready;
         default: sig = m_post_valid;
      endcase
   endfunction

   task automatic wait_for(input int k, input string name);
      int n = 0;
      while (!sig(k) && n < 20) begin
         step();
         n++;
      end
      if (!sig(k)) begin
         n_vec++; n_fail++;
         $display("FAIL %s: got timeout after %0d cycles, required handshake", name, n);
      end
   endtask

   function automatic void exp_req(input logic [63:0] a, input logic w,
                                   input logic [63:0] d, input logic [7:0] s);
      req_e e;
      e.addr = a; e.wen = w; e.wdata = d; e.wstrb = s;
      req_q.push_back(e);
      n_req_exp++;
   endfunction

   function automatic void exp_post(input logic [63:0] r, input logic f,
                                    input logic [63:0] fa, input int lat);
      post_e e;
      e.regld = r; e.fault = f; e.fa = fa; e.lat = lat;
      post_q.push_back(e);
      n_post_exp++;
   endfunction

   // One op: accept, optional bus phase with stalls, then result handshake
   task automatic do_op(input logic s64, input logic me, input logic [3:0] o,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic bus_phase, input logic [63:0] rd,
                        input logic err, input int dq, input int dr, input int dp);
      sel = s64; mem_en = me; opt = o; addr = a; regst = d;
      pre_valid = 1'b1;
      wait_for(0, "accept");
      step();
      pre_valid = 1'b0;
      if (bus_phase) begin
         n_rsp_exp++;
         repeat (dq) step();
         req_ready = 1'b1;
         wait_for(1, "req_wait");
         step();
         req_ready = 1'b0;
         repeat (dr) step();
         rsp_valid = 1'b1; rsp_data = rd; rsp_err = err;
         wait_for(2, "rsp_wait");
         step();
         rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
      end
      repeat (dp) step();
      post_ready = 1'b1;
      wait_for(3, "post_wait");
      step();
      post_ready = 1'b0;
      step();
   endtask

   // ---------------- directed vectors ----------------
   initial begin
      repeat (3) step();
      rst = 1'b0;

      // Reset state of both widths
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk("rst_pre_ready",  64'(m_pre_ready), 64'd1);
         chk("rst_post_valid", 64'(m_post_valid), 64'd0);
         chk("rst_req_valid",  64'(m_req_valid), 64'd0);
         chk("rst_rsp_ready",  64'(m_rsp_ready), 64'd0);
         chk("rst_fault",      64'(m_fault), 64'd0);
         chk("rst_regld",      m_regld, 64'd0);
         chk("rst_fault_addr", m_fault_addr, 64'd0);
      end

      // XLEN=32 SW, zero wait states: handshake three edges after accept
      exp_req(64'h8000_0004, 1'b1, 64'hDEAD_BEEF, 8'hF);
      exp_post(64'h0, 1'b0, 64'h0, 3);
      do_op(1'b0, 1'b1, 4'b1010, 64'h8000_0004, 64'hDEAD_BEEF, 1'b1, 64'h0, 1'b0, 0, 0, 0);

      // LB / LBU from the top byte lane
      exp_req(64'h8000_0000, 1'b0, 64'h0, 8'h0);
      exp_post(64'hFFFF_FF80, 1'b0, 64'h0, 3);
      do_op(1'b0, 1'b1, 4'b0000, 64'h8000_0003, 64'h0, 1'b1, 64'h80FF_0000, 1'b0, 0, 0, 0);
      exp_req(64'h8000_0000, 1'b0, 64'h0, 8'h0);
      exp_post(64'h0000_0080, 1'b0, 64'h0, -1);
      do_op(1'b0, 1'b1, 4'b0100, 64'h8000_0003, 64'h0, 1'b1, 64'h80FF_0000, 1'b0, 0, 0, 0);

      // SH into the upper halfword
      exp_req(64'h8000_0000, 1'b1, 64'h1234_0000, 8'hC);
      exp_post(64'h0, 1'b0, 64'h0, -1);
      do_op(1'b0, 1'b1, 4'b1001, 64'h8000_0002, 64'h0000_1234, 1'b1, 64'h0, 1'b0, 0, 0, 0);

      // Misaligned LW: no request, fault with original address
      exp_post(64'h0, 1'b1, 64'h8000_0002, -1);
      do_op(1'b0, 1'b1, 4'b0010, 64'h8000_0002, 64'h0, 1'b0, 64'h0, 1'b0, 0, 0, 0);

      // Doubleword on a 32-bit datapath always faults
      exp_post(64'h0, 1'b1, 64'h8000_0000, -1);
      do_op(1'b0, 1'b1, 4'b0011, 64'h8000_0000, 64'h0, 1'b0, 64'h0, 1'b0, 0, 0, 0);

      // Pass-through ignores alignment and returns zero
      exp_post(64'h0, 1'b0, 64'h0, -1);
      do_op(1'b0, 1'b0, 4'b0010, 64'h0000_0001, 64'h5555_5555, 1'b0, 64'h0, 1'b0, 0, 0, 0);

      // Back-pressure on all three interfaces, LH signed from lane 2
      exp_req(64'h8000_0004, 1'b0, 64'h0, 8'h0);
      exp_post(64'hFFFF_ABCD, 1'b0, 64'h0, -1);
      do_op(1'b0, 1'b1, 4'b0001, 64'h8000_0006, 64'h0, 1'b1, 64'hABCD_0000, 1'b0, 4, 3, 2);

      // Bus error on LW
      exp_req(64'h8000_0008, 1'b0, 64'h0, 8'h0);
      exp_post(64'h0, 1'b1, 64'h8000_0008, -1);
      do_op(1'b0, 1'b1, 4'b0010, 64'h8000_0008, 64'h0, 1'b1, 64'h1234_5678, 1'b1, 0, 1, 0);

      // Plain aligned LW
      exp_req(64'h8000_0010, 1'b0, 64'h0, 8'h0);
      exp_post(64'hCAFE_F00D, 1'b0, 64'h0, -1);
      do_op(1'b0, 1'b1, 4'b0010, 64'h8000_0010, 64'h0, 1'b1, 64'hCAFE_F00D, 1'b0, 0, 0, 0);

      // XLEN=64: LD, sign-extended LW from upper word, SB into the top lane
      exp_req(64'h10, 1'b0, 64'h0, 8'h00);
      exp_post(64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 3);
      do_op(1'b1, 1'b1, 4'b0011, 64'h10, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0, 0);
      exp_req(64'h10, 1'b0, 64'h0, 8'h00);
      exp_post(64'hFFFF_FFFF_8000_0000, 1'b0, 64'h0, -1);
      do_op(1'b1, 1'b1, 4'b0010, 64'h14, 64'h0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 0, 0, 0);
      exp_req(64'h10, 1'b1, 64'hAB00_0000_0000_0000, 8'h80);
      exp_post(64'h0, 1'b0, 64'h0, -1);
      do_op(1'b1, 1'b1, 4'b1000, 64'h17, 64'hAB, 1'b1, 64'h0, 1'b0, 0, 0, 0);
      exp_post(64'h0, 1'b1, 64'h0C, -1);
      do_op(1'b1, 1'b1, 4'b0011, 64'h0C, 64'h0, 1'b0, 64'h0, 1'b0, 0, 0, 0);

      // Reset while waiting for the response; the late response is ignored
      sel = 1'b0; mem_en = 1'b1; opt = 4'b0010; addr = 64'h8000_0020;
      exp_req(64'h8000_0020, 1'b0, 64'h0, 8'h0);
      pre_valid = 1'b1;
      wait_for(0, "rst_accept");
      step();
      pre_valid = 1'b0;
      req_ready = 1'b1;
      wait_for(1, "rst_req_wait");
      step();
      req_ready = 1'b0;
      chk("rsp_ready_in_rsp", 64'(m_rsp_ready), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_pre_ready",  64'(m_pre_ready), 64'd1);
      chk("midrst_post_valid", 64'(m_post_valid), 64'd0);
      chk("midrst_rsp_ready",  64'(m_rsp_ready), 64'd0);
      rsp_valid = 1'b1; rsp_data = 64'h1111_2222;
      step();
      rsp_valid = 1'b0; rsp_data = '0;
      step();
      chk("late_rsp_post_valid", 64'(m_post_valid), 64'd0);
      chk("late_rsp_pre_ready",  64'(m_pre_ready), 64'd1);
      chk("late_rsp_regld",      m_regld, 64'd0);

      // Exactly one handshake per expected transfer on every interface
      chk("req_handshakes",  64'(n_req_hs),  64'(n_req_exp));
      chk("rsp_handshakes",  64'(n_rsp_hs),  64'(n_rsp_exp));
      chk("post_handshakes", 64'(n_post_hs), 64'(n_post_exp));
      chk("req_q_left",      64'(req_q.size()),  64'd0);
      chk("post_q_left",     64'(post_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
